// File: rtl/neuron_mac_quantizer.sv
// Dot-product MAC with bias, saturating quantizer to a sigmoid LUT address,
// and a registered valid/ready output stage for the returned activation.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_ACC    | accept (x, w) beats, accumulate products (bias on first)
// S_QUANT  | clamp accumulator to LUT range, register io_lut_addr
// S_LOOKUP | capture io_lut_data into io_out_data, raise io_out_valid
// S_OUT    | hold result until downstream handshake, then clear
module neuron_mac_quantizer #(
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8,
    parameter int ACC_W      = 40,
    parameter int ADDR_W     = 10,
    parameter int OUT_W      = 10,
    parameter int RANGE_LOG2 = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [DATA_W-1:0] io_in_data,
    input  logic [DATA_W-1:0] io_in_weight,
    input  logic              io_in_last,
    input  logic [DATA_W-1:0] io_bias,
    output logic [ADDR_W-1:0] io_lut_addr,
    input  logic [OUT_W-1:0]  io_lut_data,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [OUT_W-1:0]  io_out_data,
    output logic [15:0]       io_count
);

    typedef enum logic [1:0] {S_ACC, S_QUANT, S_LOOKUP, S_OUT} state_t;

    // TOP is the sign bit position of the clamped sum; SHIFT drops the
    // fractional bits the LUT cannot resolve.
    localparam int TOP   = RANGE_LOG2 + 2*FRAC_W;
    localparam int SHIFT = 2*FRAC_W - (ADDR_W - 1 - RANGE_LOG2);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_HI  = {{(ACC_W-TOP){1'b0}}, {TOP{1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO  = {{(ACC_W-TOP){1'b1}}, {TOP{1'b0}}};

    state_t state, state_next;

    logic signed [ACC_W-1:0]    acc;
    logic                       first;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    acc_base;
    logic signed [ACC_W:0]      sum_wide;
    logic signed [ACC_W-1:0]    acc_sum;
    logic [ADDR_W-1:0]          quant_addr;
    logic                       in_fire;
    logic                       out_fire;

    assign io_in_ready = (state == S_ACC);
    assign in_fire     = io_in_valid && io_in_ready;
    assign out_fire    = io_out_valid && io_out_ready;

    assign prod = $signed({{DATA_W{io_in_data[DATA_W-1]}}, io_in_data}) *
                  $signed({{DATA_W{io_in_weight[DATA_W-1]}}, io_in_weight});
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W-FRAC_W){io_bias[DATA_W-1]}}, io_bias, {FRAC_W{1'b0}}};

    // The first beat of a vector adds onto the bias instead of the old sum,
    // so one saturating adder serves both cases.
    always_comb begin
        acc_base = first ? bias_ext : acc;
        sum_wide = {acc_base[ACC_W-1], acc_base} + {prod_ext[ACC_W-1], prod_ext};
        acc_sum  = sum_wide[ACC_W-1:0];
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            acc_sum = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Within range, floor(sum >> SHIFT) + half-scale is the shifted slice
    // with its sign bit inverted.
    always_comb begin
        quant_addr = {~acc[TOP], acc[TOP-1:SHIFT]};
        if (acc > SAT_HI) begin
            quant_addr = '1;
        end else if (acc < SAT_LO) begin
            quant_addr = '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_ACC:    if (in_fire && io_in_last) state_next = S_QUANT;
            S_QUANT:  state_next = S_LOOKUP;
            S_LOOKUP: state_next = S_OUT;
            S_OUT:    if (out_fire) state_next = S_ACC;
            default:  state_next = S_ACC;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_ACC;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc          <= '0;
            first        <= 1'b1;
            io_count     <= '0;
            io_lut_addr  <= '0;
            io_out_valid <= 1'b0;
            io_out_data  <= '0;
        end else begin
            case (state)
                S_ACC: begin
                    if (in_fire) begin
                        acc   <= acc_sum;
                        first <= 1'b0;
                        if (io_count != 16'hFFFF) io_count <= io_count + 16'd1;
                    end
                end
                S_QUANT: io_lut_addr <= quant_addr;
                S_LOOKUP: begin
                    io_out_data  <= io_lut_data;
                    io_out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_fire) begin
                        io_out_valid <= 1'b0;
                        acc          <= '0;
                        first        <= 1'b1;
                        io_count     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_quantizer.sv
// Bench for neuron_mac_quantizer: fixed vector table, stall and reset
// sequences, then random vectors against an integer reference model.
module tb_neuron_mac_quantizer;

    logic        clock = 0;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [15:0] io_in_data;
    logic [15:0] io_in_weight;
    logic        io_in_last;
    logic [15:0] io_bias;
    logic [9:0]  io_lut_addr;
    logic [9:0]  io_lut_data;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [9:0]  io_out_data;
    logic [15:0] io_count;

    int checks = 0;
    int failures = 0;

    logic [15:0] vx [0:7];
    logic [15:0] vw [0:7];
    logic [9:0]  last_addr;

    typedef struct {
        logic [15:0]      bias;
        int               n;
        logic [3:0][15:0] x;
        logic [3:0][15:0] w;
        logic [9:0]       exp_addr;
    } vec_t;

    vec_t tbl [0:9];

    neuron_mac_quantizer dut (
        .clock(clock), .reset(reset),
        .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
        .io_in_data(io_in_data), .io_in_weight(io_in_weight),
        .io_in_last(io_in_last), .io_bias(io_bias),
        .io_lut_addr(io_lut_addr), .io_lut_data(io_lut_data),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
        .io_out_data(io_out_data), .io_count(io_count)
    );

    always #5 clock = ~clock;

    function automatic logic [9:0] lut_f(input logic [9:0] a);
        return 10'(a * 37 + 11);
    endfunction

    assign io_lut_data = lut_f(io_lut_addr);

    // Real-valued rule in integer form: Q16.16 sum, clamp, floor divide.
    function automatic logic [9:0] model_addr(input logic [15:0] bias, input int n);
        longint s;
        s = longint'($signed(bias)) * 256;
        for (int i = 0; i < n; i++) begin
            s = s + longint'($signed(vx[i])) * longint'($signed(vw[i]));
            if (s > 64'sd549755813887) s = 64'sd549755813887;
            if (s < -64'sd549755813888) s = -64'sd549755813888;
        end
        if (s > 524287) s = 524287;
        if (s < -524288) s = -524288;
        return 10'((s >>> 10) + 512);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [15:0] x, input logic [15:0] w, input logic last);
        int g;
        @(negedge clock);
        io_in_valid  = 1;
        io_in_data   = x;
        io_in_weight = w;
        io_in_last   = last;
        g = 0;
        while (!io_in_ready && g < 20) begin
            @(negedge clock);
            g++;
        end
        if (!io_in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clock);
        #1 io_in_valid = 0;
        io_in_last = 0;
    endtask

    task automatic run_vector(input string name, input logic [15:0] bias, input int n,
                              input logic [9:0] exp_addr, input int stall);
        logic [9:0] held;
        io_bias = bias;
        for (int i = 0; i < n; i++) send_beat(vx[i], vw[i], i == n - 1);
        @(negedge clock);
        chk({name, "_ready_quant"}, io_in_ready, 0);
        chk({name, "_addr_hold"}, io_lut_addr, last_addr);
        @(negedge clock);
        chk({name, "_addr"}, io_lut_addr, exp_addr);
        chk({name, "_valid_early"}, io_out_valid, 0);
        @(negedge clock);
        chk({name, "_valid"}, io_out_valid, 1);
        chk({name, "_data"}, io_out_data, lut_f(exp_addr));
        chk({name, "_count"}, io_count, n);
        held = io_out_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            chk({name, "_stall_valid"}, io_out_valid, 1);
            chk({name, "_stall_data"}, io_out_data, held);
            chk({name, "_stall_ready"}, io_in_ready, 0);
        end
        io_out_ready = 1;
        @(negedge clock);
        io_out_ready = 0;
        chk({name, "_valid_clear"}, io_out_valid, 0);
        chk({name, "_ready_back"}, io_in_ready, 1);
        chk({name, "_count_clear"}, io_count, 0);
        last_addr = exp_addr;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'h0000, 1, {16'h0, 16'h0, 16'h0, 16'h0100}, {16'h0, 16'h0, 16'h0, 16'h0100}, 10'd576};
        tbl[1] = '{16'h0000, 2, {16'h0, 16'h0, 16'hFE00, 16'h0200}, {16'h0, 16'h0, 16'h0080, 16'h0080}, 10'd512};
        tbl[2] = '{16'h0A00, 1, '0, '0, 10'd1023};
        tbl[3] = '{16'hF600, 1, '0, '0, 10'd0};
        tbl[4] = '{16'hFFFF, 1, '0, '0, 10'd511};
        tbl[5] = '{16'h0000, 1, {16'h0, 16'h0, 16'h0, 16'h0080}, {16'h0, 16'h0, 16'h0, 16'h0100}, 10'd544};
        tbl[6] = '{16'h0700, 1, {16'h0, 16'h0, 16'h0, 16'h0100}, {16'h0, 16'h0, 16'h0, 16'h00FF}, 10'd1023};
        tbl[7] = '{16'h0800, 1, '0, '0, 10'd1023};
        tbl[8] = '{16'hF800, 1, '0, '0, 10'd0};
        tbl[9] = '{16'hF804, 1, '0, '0, 10'd1};

        reset = 1; io_in_valid = 0; io_in_data = 0; io_in_weight = 0;
        io_in_last = 0; io_bias = 0; io_out_ready = 0; last_addr = 0;
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 0;
        @(negedge clock);
        chk("rst_ready", io_in_ready, 1);
        chk("rst_count", io_count, 0);
        chk("rst_addr", io_lut_addr, 0);
        chk("rst_valid", io_out_valid, 0);
        chk("rst_data", io_out_data, 0);

        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < tbl[t].n; i++) begin
                vx[i] = tbl[t].x[i];
                vw[i] = tbl[t].w[i];
            end
            run_vector($sformatf("tbl%0d", t), tbl[t].bias, tbl[t].n, tbl[t].exp_addr, 0);
        end

        vx[0] = 16'h0000; vw[0] = 16'h0000;
        run_vector("stall", 16'h0100, 1, 10'd576, 5);
        run_vector("after_stall", 16'hFF00, 1, 10'd448, 0);

        io_bias = 16'h0300;
        for (int i = 0; i < 3; i++) send_beat(16'h0400, 16'h0100, 0);
        @(negedge clock);
        chk("abort_count", io_count, 3);
        reset = 1;
        @(negedge clock);
        reset = 0;
        chk("abort_ready", io_in_ready, 1);
        chk("abort_count_clr", io_count, 0);
        chk("abort_valid", io_out_valid, 0);
        last_addr = 0;
        vx[0] = 16'h0100; vw[0] = 16'h0100;
        run_vector("post_abort", 16'h0000, 1, 10'd576, 0);

        for (int r = 0; r < 40; r++) begin
            int n;
            logic [15:0] b;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                if (r % 2 == 0) begin
                    vx[i] = 16'($signed($urandom_range(0, 1023)) - 512);
                    vw[i] = 16'($signed($urandom_range(0, 1023)) - 512);
                end else begin
                    vx[i] = 16'($urandom);
                    vw[i] = 16'($urandom);
                end
            end
            b = (r % 2 == 0) ? 16'($signed($urandom_range(0, 2047)) - 1024) : 16'($urandom);
            run_vector($sformatf("rnd%0d", r), b, n, model_addr(b, n), r % 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_mac_quantizer.md
Name: neuron_mac_quantizer

Overview:
Upstream feeder of the sigmoid LUT stage in the neuron datapath. It accepts a stream of signed fixed-point (input, weight) pairs over a valid/ready handshake and accumulates their products plus a bias. It then saturates and quantizes the sum into a 10-bit LUT address and holds that address while the LUT responds. The returned activation is captured and presented downstream on a valid/ready output.

Parameters:
DATA_W, 16, width of input/weight/bias words, signed two's complement
FRAC_W, 8, fractional bits of DATA_W words (Q8.8); products are Q16.16
ACC_W, 40, accumulator width, signed, 2*FRAC_W fractional bits
ADDR_W, 10, LUT address width (1024 entries)
OUT_W, 10, LUT data / activation width
RANGE_LOG2, 3, LUT covers real input range [-2^RANGE_LOG2, +2^RANGE_LOG2)

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
io_in_valid  in  1  input beat valid
io_in_ready  out  1  block accepts a beat this cycle
io_in_data  in  DATA_W  activation input x, Q8.8
io_in_weight  in  DATA_W  weight w, Q8.8
io_in_last  in  1  marks final beat of the neuron's dot product
io_bias  in  DATA_W  bias, Q8.8; sampled with first beat of a vector
io_lut_addr  out  ADDR_W  address to sigmoid LUT, registered
io_lut_data  in  OUT_W  LUT read data, valid combinationally for current io_lut_addr
io_out_valid  out  1  activation valid
io_out_ready  in  1  downstream accepts
io_out_data  out  OUT_W  activation result
io_count  out  16  beats accepted in current vector (saturates at 0xFFFF)

Behaviour:
- Reset (synchronous, active-high): state=ACC, acc=0, first=1, io_count=0, io_lut_addr=0, io_out_valid=0, io_out_data=0. io_in_ready=1 in the cycle after reset deasserts. Reset mid-vector discards the partial sum and any pending output.
- States: ACC -> QUANT -> LOOKUP -> OUT -> ACC.
- ACC: io_in_ready=1. Beat accepted on valid&ready.
  - When first=1, accumulator is loaded with sign-extended (bias << FRAC_W) + x*w; otherwise acc += x*w.
  - Product is full 2*DATA_W signed.
  - Accumulator add saturates to ACC_W signed min/max and never wraps.
  - Each accepted beat clears first and increments io_count.
  - An accepted beat with io_in_last=1 moves to QUANT.
- QUANT (1 cycle, io_in_ready=0):
  - Saturate acc to [-(2^RANGE_LOG2)<<16, ((2^RANGE_LOG2)<<16)-1].
  - Compute addr = (sat >> (2*FRAC_W - (ADDR_W-1-RANGE_LOG2))) + 2^(ADDR_W-1); defaults: (sat>>10)+512.
  - Truncation of the shift is arithmetic (floor). Register addr into io_lut_addr, then go to LOOKUP.
- LOOKUP (1 cycle): io_out_data <= io_lut_data; io_out_valid <= 1; go to OUT.
- OUT: io_out_valid=1 and io_out_data stable until io_out_ready=1.
  - On handshake: io_out_valid <= 0, acc=0, first=1, io_count=0, state=ACC.
  - io_in_ready=0 throughout OUT, so there is no overlap of vectors.
- Latency: last beat accepted at cycle T gives io_lut_addr valid at T+2 and io_out_valid at T+3. The minimum per-vector overhead is 3 cycles beyond the beats.
- A single-beat vector (first and last together) is legal; its sum is bias + x*w.
- io_lut_addr holds its value outside QUANT; it changes only in QUANT.
- io_in_valid with ready=0 is ignored; upstream must hold. The block never drops or duplicates a beat.

Test Plan:
- Reset, bias=0, one beat x=0x0100, w=0x0100, last=1 -> io_lut_addr=576 (64+512) at T+2; io_out_data equals LUT[576] at T+3; io_count=1.
- bias=0x0000, beats (0x0200,0x0080) and (0xFE00,0x0080, last) -> sum 0 -> io_lut_addr=512.
- bias=0x0A00 (+10.0), one beat x=0, w=0 -> sat high, io_lut_addr=1023. bias=0xF600 (-10.0) -> io_lut_addr=0.
- bias=0xFFFF (-1/256), x=w=0 -> acc=-256 in Q16.16 -> floor gives io_lut_addr=511.
- Hold io_out_ready=0 for 5 cycles after io_out_valid -> io_out_valid and io_out_data stable, io_in_ready=0. Release -> io_in_ready=1 on the next cycle and next vector accumulates from bias.
- Assert reset after 3 of 5 beats -> io_in_ready=1 and io_count=0. A new 1-beat vector (bias 0, 0x0100*0x0100) yields addr 576 with no residue from the aborted sum.
